// File: rtl/blit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : blit_pkg
// Purpose  : Shared types and constants for the sprite blit engine.
//            This file has no ports. It holds the OLED frame geometry, the
//            pixel address width, the RGB565 colour type and the blit FSM
//            state encoding.
// Revision : 1.0  initial release
// ============================================================================
package blit_pkg;

  localparam int OLED_W = 96;
  localparam int OLED_H = 64;
  localparam int PIX_AW = 13;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } blit_state_t;

endpackage
`default_nettype wire

// File: rtl/sprite_blit_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blit_engine_if
// Purpose  : Pixel buses of the blit engine.
//            Sprite ROM side:
//              src_pixel_index  ROM address (engine -> ROM)
//              src_colour       RGB565 colour, combinational from the index
//                               (ROM -> engine)
//            Framebuffer write side (engine -> framebuffer):
//              fb_we            write strobe
//              fb_addr          write address
//              fb_data          RGB565 write data
//            Modports:
//              master           the engine
//              slave            the ROM and framebuffer side
// Revision : 1.0  initial release
// ============================================================================
interface sprite_blit_engine_if;
  import blit_pkg::*;

  logic [PIX_AW-1:0] src_pixel_index;
  rgb565_t           src_colour;
  logic              fb_we;
  logic [PIX_AW-1:0] fb_addr;
  rgb565_t           fb_data;

  modport master (
    output src_pixel_index,
    input  src_colour,
    output fb_we,
    output fb_addr,
    output fb_data
  );

  modport slave (
    input  src_pixel_index,
    output src_colour,
    input  fb_we,
    input  fb_addr,
    input  fb_data
  );

endinterface
`default_nettype wire

// File: rtl/blit_coord_map.sv
`default_nettype none
// ============================================================================
// Module   : blit_coord_map
// Purpose  : Combinational source-to-destination coordinate map.
//            It applies the optional horizontal flip and the signed offsets,
//            tests the result against the frame edges and forms the
//            framebuffer address.
// Ports    : sx, sy       source column and row
//            x_off, y_off signed 8-bit placement offsets
//            mirror       horizontal flip (honoured only with BLIT_MIRROR_EN)
//            dx, dy       signed 9-bit destination coordinates
//            in_bounds    destination lies inside the frame
//            dst_addr     dy*WIDTH+dx (meaningful only when in_bounds)
// Config   : BLIT_MIRROR_EN enables the flip; otherwise mirror is ignored.
// Revision : 1.0  initial release
// ============================================================================
module blit_coord_map
  import blit_pkg::*;
#(
  parameter int WIDTH  = OLED_W,
  parameter int HEIGHT = OLED_H
) (
  input  logic [$clog2(WIDTH)-1:0]  sx,
  input  logic [$clog2(HEIGHT)-1:0] sy,
  input  logic [7:0]                x_off,
  input  logic [7:0]                y_off,
  input  logic                      mirror,
  output logic signed [8:0]         dx,
  output logic signed [8:0]         dy,
  output logic                      in_bounds,
  output logic [PIX_AW-1:0]         dst_addr
);

  localparam int SX_W = $clog2(WIDTH);
  localparam logic [8:0] W9 = 9'(WIDTH);
  localparam logic [8:0] H9 = 9'(HEIGHT);

  logic [SX_W-1:0] sxm;
  logic [8:0]      dx_u;
  logic [8:0]      dy_u;

`ifdef BLIT_MIRROR_EN
  localparam logic [SX_W-1:0] SX_LAST = SX_W'(WIDTH - 1);
  assign sxm = mirror ? (SX_LAST - sx) : sx;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign sxm           = sx;
`endif

  // The sum is kept at 9 bits so that the full range of offset plus
  // coordinate is representable. Negative results therefore clip correctly
  // instead of wrapping onto the screen.
  assign dx = $signed({x_off[7], x_off}) + $signed(9'(sxm));
  assign dy = $signed({y_off[7], y_off}) + $signed(9'(sy));

  assign dx_u = dx;
  assign dy_u = dy;

  // The sign bit is tested first. The unsigned compares are then valid.
  assign in_bounds = !dx_u[8] && (dx_u < W9) && !dy_u[8] && (dy_u < H9);

  assign dst_addr = PIX_AW'(dy_u) * PIX_AW'(WIDTH) + PIX_AW'(dx_u);

endmodule
`default_nettype wire

// File: rtl/sprite_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : sprite_blit_engine
// Purpose  : Copies one WIDTH x HEIGHT sprite from a sprite ROM into the OLED
//            framebuffer write port. It applies a signed placement offset,
//            clipping at the frame edges and a transparency colour key.
// Ports    : clk, rst_n         clock, asynchronous active-low reset
//            start              1-cycle request, accepted only in IDLE
//            x_off, y_off       signed placement, latched on accept
//            mirror             horizontal flip, latched on accept
//            busy, done         status: busy during the blit, done pulses
//                               for one cycle at the end
//            bus (master)       sprite ROM index/colour, framebuffer write
// Config   : BLIT_MIRROR_EN enables the mirror input. Without it the port is
//            present but ignored.
// Revision : 1.0  initial release
// ============================================================================
module sprite_blit_engine
  import blit_pkg::*;
#(
  parameter int      WIDTH       = OLED_W,
  parameter int      HEIGHT      = OLED_H,
  parameter rgb565_t TRANSPARENT = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            x_off,
  input  logic [7:0]            y_off,
  input  logic                  mirror,
  output logic                  busy,
  output logic                  done,
  sprite_blit_engine_if.master  bus
);

  localparam int SX_W = $clog2(WIDTH);
  localparam int SY_W = $clog2(HEIGHT);
  localparam logic [SX_W-1:0]   SX_LAST  = SX_W'(WIDTH - 1);
  localparam logic [PIX_AW-1:0] IDX_LAST = PIX_AW'(WIDTH * HEIGHT - 1);

  blit_state_t       state_q,   state_d;
  logic [SX_W-1:0]   sx_q,      sx_d;
  logic [SY_W-1:0]   sy_q,      sy_d;
  logic [PIX_AW-1:0] idx_q,     idx_d;
  logic [7:0]        x_off_q,   x_off_d;
  logic [7:0]        y_off_q,   y_off_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;
  logic              fb_we_q,   fb_we_d;
  logic [PIX_AW-1:0] fb_addr_q, fb_addr_d;
  rgb565_t           fb_data_q, fb_data_d;

  logic              map_mirror;
  logic signed [8:0] map_dx;
  logic signed [8:0] map_dy;
  logic              map_in_bounds;
  logic [PIX_AW-1:0] map_addr;

  // --------------------------------------------------------------------------
  // Mirror latch: this register exists only when the flip feature is built.
  // --------------------------------------------------------------------------
`ifdef BLIT_MIRROR_EN
  logic mirror_q, mirror_d;

  always_comb begin
    mirror_d = mirror_q;
    if (state_q == IDLE && start) mirror_d = mirror;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mirror_q <= 1'b0;
    else        mirror_q <= mirror_d;
  end

  assign map_mirror = mirror_q;
`else
  logic unused_mirror;
  assign unused_mirror = mirror;
  assign map_mirror    = 1'b0;
`endif

  blit_coord_map #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_coord_map (
    .sx        (sx_q),
    .sy        (sy_q),
    .x_off     (x_off_q),
    .y_off     (y_off_q),
    .mirror    (map_mirror),
    .dx        (map_dx),
    .dy        (map_dy),
    .in_bounds (map_in_bounds),
    .dst_addr  (map_addr)
  );

  // The map exposes the raw destination coordinates. This block only needs
  // the bounds flag and the address.
  logic unused_coords;
  assign unused_coords = ^{map_dx, map_dy};

  // --------------------------------------------------------------------------
  // Next-state logic. The ROM index is a running counter. sx and sy travel
  // with it, so the index path never needs a multiply.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    idx_d     = idx_q;
    x_off_d   = x_off_q;
    y_off_d   = y_off_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          x_off_d = x_off;
          y_off_d = y_off;
          sx_d    = '0;
          sy_d    = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end

      SCAN: begin
        // The write for the current index is registered and appears on the
        // framebuffer port one cycle later.
        if (bus.src_colour != TRANSPARENT && map_in_bounds) begin
          fb_we_d   = 1'b1;
          fb_addr_d = map_addr;
          fb_data_d = bus.src_colour;
        end
        if (idx_q == IDX_LAST) begin
          state_d = FLUSH;
        end else begin
          idx_d = idx_q + 1'b1;
          if (sx_q == SX_LAST) begin
            sx_d = '0;
            sy_d = sy_q + 1'b1;
          end else begin
            sx_d = sx_q + 1'b1;
          end
        end
      end

      // The final registered write drains during this cycle. busy and done
      // are then set up so that they switch together as DONE is entered.
      FLUSH: begin
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      idx_q     <= '0;
      x_off_q   <= '0;
      y_off_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= '0;
      fb_data_q <= '0;
    end else begin
      state_q   <= state_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      idx_q     <= idx_d;
      x_off_q   <= x_off_d;
      y_off_q   <= y_off_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign bus.src_pixel_index = idx_q;
  assign bus.fb_we           = fb_we_q;
  assign bus.fb_addr         = fb_addr_q;
  assign bus.fb_data         = fb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blit_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_blit_engine
// Purpose  : Self-checking bench for sprite_blit_engine.
//            A sprite ROM array drives the colour input. The expected write
//            list of each blit is derived directly from the placement,
//            clipping and transparency rules, and the observed writes,
//            timing and status are compared against it.
// Revision : 1.0  initial release
// ============================================================================
module tb_sprite_blit_engine;
  import blit_pkg::*;

  localparam int W = 96;
  localparam int H = 64;
  localparam int N = W * H;
`ifdef BLIT_MIRROR_EN
  localparam bit MIRROR_ON = 1'b1;
`else
  localparam bit MIRROR_ON = 1'b0;
`endif

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic       mirror = 1'b0;
  logic [7:0] x_off  = 8'h00;
  logic [7:0] y_off  = 8'h00;
  logic       busy;
  logic       done;

  sprite_blit_engine_if bus();

  sprite_blit_engine #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .TRANSPARENT (16'h0000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .x_off  (x_off),
    .y_off  (y_off),
    .mirror (mirror),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [15:0] rom [0:N-1];
  assign bus.src_colour = (int'(bus.src_pixel_index) < N) ? rom[bus.src_pixel_index] : 16'h0000;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_cyc[$];
  int exp_addr[$];
  int exp_data[$];
  int act_cyc[$];
  int act_addr[$];
  int act_data[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < N; i++) rom[i] = 16'h0000;
  endtask

  task automatic rom_random();
    for (int i = 0; i < N; i++)
      rom[i] = ($urandom_range(0, 7) == 0) ? (16'($urandom) | 16'h0001) : 16'h0000;
  endtask

  // Expected write list. Source pixel k is presented at cycle k+1 after the
  // accept, so its write lands at cycle k+2.
  task automatic model(input logic [7:0] xo, input logic [7:0] yo, input logic m);
    int sxm, dx, dy, k;
    exp_cyc.delete(); exp_addr.delete(); exp_data.delete();
    for (int sy = 0; sy < H; sy++) begin
      for (int sx = 0; sx < W; sx++) begin
        k   = sy * W + sx;
        sxm = (m && MIRROR_ON) ? (W - 1 - sx) : sx;
        dx  = int'($signed(xo)) + sxm;
        dy  = int'($signed(yo)) + sy;
        if (rom[k] != 16'h0000 && dx >= 0 && dx < W && dy >= 0 && dy < H) begin
          exp_cyc.push_back(k + 2);
          exp_addr.push_back(dy * W + dx);
          exp_data.push_back(int'(rom[k]));
        end
      end
    end
  endtask

  // mode 0: plain blit; 1: extra start pulse mid-blit; 2: reset at cycle 100
  task automatic run_blit(input string name, input logic [7:0] xo, input logic [7:0] yo,
                          input logic m, input int mode);
    int busy_cnt, done_cnt, done_cyc, limit, n;
    model(xo, yo, m);
    if (mode == 2) while (exp_cyc.size() > 0 && exp_cyc[$] > 100) begin
      void'(exp_cyc.pop_back()); void'(exp_addr.pop_back()); void'(exp_data.pop_back());
    end
    act_cyc.delete(); act_addr.delete(); act_data.delete();
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    limit = (mode == 2) ? 300 : N + 40;

    @(negedge clk);
    x_off = xo; y_off = yo; mirror = m; start = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (c == 1) begin
        // Change the inputs after the accept. A correct design keeps the
        // latched values.
        start = 1'b0; x_off = ~xo; y_off = ~yo; mirror = ~m;
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus.fb_we) begin
        act_cyc.push_back(c);
        act_addr.push_back(int'(bus.fb_addr));
        act_data.push_back(int'(bus.fb_data));
      end
      if (mode == 1 && c == 50) start = 1'b1;
      if (mode == 1 && c == 51) start = 1'b0;
      if (mode == 2 && c == 100) begin
        check({name, " pre_rst_busy"}, 32'(busy), 32'd1);
        check({name, " pre_rst_we"}, 32'(bus.fb_we), 32'd1);
        rst_n = 1'b0;
        #1;
        check({name, " rst_busy"}, 32'(busy), 32'd0);
        check({name, " rst_we"}, 32'(bus.fb_we), 32'd0);
        check({name, " rst_done"}, 32'(done), 32'd0);
      end
      if (mode == 2 && c == 105) rst_n = 1'b1;
      if (mode != 2 && done_cyc > 0 && c >= done_cyc + 3) break;
    end

    check({name, " wr_count"}, 32'(act_cyc.size()), 32'(exp_cyc.size()));
    n = (act_cyc.size() < exp_cyc.size()) ? act_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s wr%0d_cyc", name, i), 32'(act_cyc[i]), 32'(exp_cyc[i]));
      check($sformatf("%s wr%0d_addr", name, i), 32'(act_addr[i]), 32'(exp_addr[i]));
      check($sformatf("%s wr%0d_data", name, i), 32'(act_data[i]), 32'(exp_data[i]));
    end
    check({name, " we_after"}, 32'(bus.fb_we), 32'd0);
    if (mode == 2) begin
      check({name, " done_cnt"}, 32'(done_cnt), 32'd0);
      check({name, " busy_cycles"}, 32'(busy_cnt), 32'd100);
      check({name, " idx_after"}, 32'(bus.src_pixel_index), 32'd0);
    end else begin
      check({name, " done_cyc"}, 32'(done_cyc), 32'(N + 2));
      check({name, " done_cnt"}, 32'(done_cnt), 32'd1);
      check({name, " busy_cycles"}, 32'(busy_cnt), 32'(N + 1));
      check({name, " idx_held"}, 32'(bus.src_pixel_index), 32'(N - 1));
      if (exp_addr.size() > 0) begin
        check({name, " addr_held"}, 32'(bus.fb_addr), 32'(exp_addr[$]));
        check({name, " data_held"}, 32'(bus.fb_data), 32'(exp_data[$]));
      end
    end
  endtask

  initial begin
    rom_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_we", 32'(bus.fb_we), 32'd0);
    check("reset_idx", 32'(bus.src_pixel_index), 32'd0);
    check("reset_addr", 32'(bus.fb_addr), 32'd0);
    check("reset_data", 32'(bus.fb_data), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single pixel at idx 1968, no offset.
    rom_clear(); rom[1968] = 16'hD54B;
    run_blit("t1", 8'd0, 8'd0, 1'b0, 0);
    check("t1 first_cyc", 32'(act_cyc.size() > 0 ? act_cyc[0] : -1), 32'd1970);
    check("t1 first_addr", 32'(act_addr.size() > 0 ? act_addr[0] : -1), 32'd1968);

    // Left clip with a negative offset.
    rom_clear(); rom[5] = 16'h1234; rom[20] = 16'h5678;
    run_blit("t2", 8'hF6, 8'd0, 1'b0, 0);
    check("t2 first_addr", 32'(act_addr.size() > 0 ? act_addr[0] : -1), 32'd10);

    // Right/bottom edges: one pixel clipped, the other at the bottom row.
    rom_clear(); rom[2 * W + 10] = 16'hAAAA; rom[3 * W + 3] = 16'h5555;
    run_blit("t3", 8'd90, 8'd60, 1'b0, 0);
    check("t3 first_addr", 32'(act_addr.size() > 0 ? act_addr[0] : -1), 32'(63 * W + 93));

    // Mirror request with a single corner pixel.
    rom_clear(); rom[0] = 16'hFFFF;
    run_blit("t4", 8'd0, 8'd0, 1'b1, 0);
    check("t4 first_addr", 32'(act_addr.size() > 0 ? act_addr[0] : -1), MIRROR_ON ? 32'd95 : 32'd0);

    // Extra start pulse while the engine is busy.
    rom_random();
    run_blit("t5", 8'(int'($urandom_range(0, 40)) - 20), 8'(int'($urandom_range(0, 30)) - 15), 1'($urandom), 1);

    // All-transparent sprite.
    rom_clear();
    run_blit("t6", 8'd3, 8'd4, 1'b0, 0);

    // Sprite placed entirely off-screen.
    rom_random();
    run_blit("t7", 8'd100, 8'd0, 1'b0, 0);

    // Reset asserted mid-blit while writes are streaming.
    for (int i = 0; i < N; i++) rom[i] = 16'($urandom) | 16'h0001;
    run_blit("t8", 8'd0, 8'd0, 1'b0, 2);

    // Random placements and contents.
    for (int r = 0; r < 3; r++) begin
      rom_random();
      run_blit($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
               1'($urandom), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
